counter_mod_nbit: RTL

Parametrised modulo-MOD up/down counter with synchronous clear, parallel load, terminal-count output and a registered wrap pulse. It generalises the plain free-running n-bit counter used throughout the clock design. Each stage counts within 0..MOD-1 and signals carry/borrow, so seconds, minutes and hours digits are built by cascading stages, with `tc` of one stage driving `enable` of the next.

---
 rtl/counter_mod_nbit.sv | 76 +++++++
 1 files changed

// File: rtl/counter_mod_nbit.sv
// Modulo-MOD up/down counter stage with synchronous clear, clamped parallel load,
// combinational terminal count for cascading, and a registered one-cycle wrap pulse.
module counter_mod_nbit #(
  parameter int N    = 4,
  parameter int MOD  = 10,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         enable,
  input  logic         up,
  output logic [N-1:0] P,
  output logic         tc,
  output logic         wrapped
);

  // Largest legal count; for MOD = 2^N this is all ones, so no N+1-bit value is needed.
  localparam logic [N-1:0] MAX = N'(MOD - 1);

  if (MOD < 2 || MOD > (2 ** N)) begin : g_bad_mod
    $error("counter_mod_nbit: MOD must lie in 2..2**N");
  end

  logic         at_max;
  logic         at_zero;
  logic [N-1:0] p_next;
  logic         wrap_next;

  assign at_max  = (P == MAX);
  assign at_zero = (P == '0);

  // Carry/borrow for the next stage; suppressed whenever clear or load owns the edge.
  assign tc = enable & ~clear & ~load & ((up & at_max) | (~up & at_zero));

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    p_next    = P;
    wrap_next = 1'b0;
    if (clear) begin
      p_next = '0;
    end else if (load) begin
      p_next = (d > MAX) ? MAX : d;
    end else if (enable) begin
      if (up) begin
        if (!at_max) begin
          p_next = P + N'(1);
        end else if (WRAP) begin
          p_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          p_next = P - N'(1);
        end else if (WRAP) begin
          p_next    = MAX;
          wrap_next = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      P       <= '0;
      wrapped <= 1'b0;
    end else begin
      P       <= p_next;
      wrapped <= wrap_next;
    end
  end

endmodule
